arm_elastic_pipe: RTL and testbench
===================================

// Module: arm_elastic_pipe
// PURPOSE
//  Parametrised elastic pipeline-register chain for the ARM core datapath.
//  Replaces the fixed IF/ID/EX/MEM stage registers with one STAGES-deep, WIDTH-bit payload chain.
//  Adds valid/ready back-pressure, per-stage bubble collapsing, global freeze,
//  masked flush (branch-taken) and an occupancy count.
//  Sits between producer and consumer stages; one instance per pipeline segment.
// PARAMETERS
//  WIDTH       32        payload bits per stage (>=1)
//  STAGES      4         register stages (>=1); stage 0 = input side, STAGES-1 = output side
//  FLUSH_MASK  4'b1111   STAGES bits; bit i=1 -> stage i invalidated by flush
// PORTS
//  clk        in   1                  rising-edge clock
//  rst        in   1                  synchronous, active-high reset
//  in_valid   in   1                  producer offers in_data
//  in_data    in   WIDTH              payload into stage 0
//  in_ready   out  1                  chain accepts in_data this cycle
//  out_valid  out  1                  stage STAGES-1 holds a valid item
//  out_data   out  WIDTH              payload of stage STAGES-1
//  out_ready  in   1                  consumer takes out_data this cycle
//  freeze     in   1                  hold every stage (hazard stall)
//  flush      in   1                  invalidate stages selected by FLUSH_MASK
//  count      out  $clog2(STAGES+1)   number of valid stages (registered)
// BEHAVIOUR
//  - Reset (rst=1 at clk edge): all valid bits 0, all data regs 0, count 0; stats counters 0.
//    Reset overrides flush, freeze and any pending transfer.
//  - Per stage: valid[i], data[i]. Combinational terms, S=STAGES:
//      adv[S-1] = valid[S-1] & out_ready & ~freeze & ~(flush & FLUSH_MASK[S-1])
//      space[i] = ~valid[i] | adv[i]
//      adv[i<S-1] = valid[i] & space[i+1] & ~freeze
//      in_ready = space[0] & ~freeze & ~flush;   accept = in_valid & in_ready
//  - out_valid = valid[S-1] & ~freeze & ~(flush & FLUSH_MASK[S-1]); out_data = data[S-1] always.
//  - Next state: stage i+1 loads data[i] when adv[i]; stage 0 loads in_data on accept;
//    a stage that advances and receives nothing goes invalid; others hold.
//  - Bubble collapse: a stalled output lets upstream items close gaps in the same cycle.
//  - flush=1: after the edge, valid[i]=0 for every i with FLUSH_MASK[i]=1 (incl. items that
//    would have moved in); unmasked stages advance normally. Flush overrides freeze.
//    Data regs are not cleared by flush.
//  - freeze=1 (no flush): no valid or data change; in_ready=0, out_valid=0.
//  - Latency: empty chain, no stall: accept at edge k -> out_valid high in the cycle after
//    edge k+STAGES-1 (STAGES cycles). Throughput 1 item/cycle while out_ready=1.
//  - Full: all valid & ~out_ready -> in_ready=0; simultaneous in/out when full is legal
//    (adv ripples, in_ready=1 if out_ready=1).
//  - count = popcount of valid after each edge; never exceeds STAGES.
//  - STAGES=1: single register with same rules (in_ready = ~valid[0] | adv[0]).
// CONFIGURATION
//  ARM_ELASTIC_PIPE_STATS_EN defined: adds outputs stall_cnt [31:0] (cycles with
//    in_valid & ~in_ready) and flush_cnt [31:0] (valid items destroyed by flush, summed
//    per cycle); both saturate at 32'hFFFF_FFFF, cleared by rst.
//  Not defined: ports and counters absent; core behaviour identical.
// TESTING
//  1 Reset: drive in_valid=1 with rst=1 for 3 cycles -> in_ready=1, out_valid=0, count=0, nothing
//    stored.
//  2 Streaming: STAGES=4, out_ready=1, push 0x1..0x8 back-to-back -> out_data 0x1 valid 4 cycles
//    after first accept, then 0x2..0x8 on consecutive cycles, count=4 steady.
//  3 Back-pressure/collapse: push A,idle,B,idle,C, hold out_ready=0 -> all three packed, count=3;
//    push D -> count=4, in_ready=0; release -> A,B,C,D in order, no duplicates or losses.
//  4 Freeze: mid-stream freeze 3 cycles -> valid/data/count unchanged, in_ready=0, out_valid=0;
//    resumes exactly where stopped.
//  5 Flush: FLUSH_MASK=4'b0011, all 4 stages full, out_ready=0, flush 1 cycle -> count=2, stages 2,3
//    kept; simultaneous in_valid=1 not accepted; flush+freeze together still flushes.
//  6 STATS_EN: scenario 3 then 5 -> stall_cnt = cycles in_valid&~in_ready, flush_cnt=2.

Source files
------------

// File: rtl/arm_elastic_pipe.sv
// Elastic valid/ready register chain with bubble collapse, freeze, masked flush and occupancy count.
// Optional ARM_ELASTIC_PIPE_STATS_EN adds saturating stall_cnt / flush_cnt outputs.
module arm_elastic_pipe #(
   parameter int                WIDTH      = 32,
   parameter int                STAGES     = 4,
   parameter logic [STAGES-1:0] FLUSH_MASK = {STAGES{1'b1}}
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   input  logic [WIDTH-1:0]             in_data,
   output logic                         in_ready,
   output logic                         out_valid,
   output logic [WIDTH-1:0]             out_data,
   input  logic                         out_ready,
   input  logic                         freeze,
   input  logic                         flush,
   output logic [$clog2(STAGES+1)-1:0]  count
`ifdef ARM_ELASTIC_PIPE_STATS_EN
   ,
   output logic [31:0]                  stall_cnt,
   output logic [31:0]                  flush_cnt
`endif
);

   localparam int CW = $clog2(STAGES+1);

   logic [STAGES-1:0] valid_q, valid_d, valid_pre;
   logic [WIDTH-1:0]  data_q [STAGES];
   logic [WIDTH-1:0]  data_d [STAGES];
   logic [STAGES-1:0] adv, space, kill;
   logic [CW-1:0]     count_q, count_d;
   logic              accept;

   function automatic logic [CW-1:0] popcount(input logic [STAGES-1:0] v);
      logic [CW-1:0] n;
      n = '0;
      for (int i = 0; i < STAGES; i++) n = n + CW'(v[i]);
      return n;
   endfunction

   function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [CW-1:0] inc);
      logic [32:0] s;
      s = {1'b0, a} + 33'(inc);
      return s[32] ? 32'hFFFF_FFFF : s[31:0];
   endfunction

   // Advance terms ripple from the output side so a stalled head lets upstream gaps close.
   always_comb begin
      adv   = '0;
      space = '0;
      adv[STAGES-1]   = valid_q[STAGES-1] & out_ready & ~freeze & ~(flush & FLUSH_MASK[STAGES-1]);
      space[STAGES-1] = ~valid_q[STAGES-1] | adv[STAGES-1];
      for (int i = STAGES-2; i >= 0; i--) begin
         adv[i]   = valid_q[i] & space[i+1] & ~freeze;
         space[i] = ~valid_q[i] | adv[i];
      end
   end

   assign in_ready  = space[0] & ~freeze & ~flush;
   assign accept    = in_valid & in_ready;
   assign out_valid = valid_q[STAGES-1] & ~freeze & ~(flush & FLUSH_MASK[STAGES-1]);
   assign out_data  = data_q[STAGES-1];
   assign count     = count_q;

   always_comb begin
      valid_pre    = '0;
      valid_pre[0] = accept | (valid_q[0] & ~adv[0]);
      data_d[0]    = accept ? in_data : data_q[0];
      for (int i = 1; i < STAGES; i++) begin
         valid_pre[i] = adv[i-1] | (valid_q[i] & ~adv[i]);
         data_d[i]    = adv[i-1] ? data_q[i-1] : data_q[i];
      end
      // Flush applies after movement, so items moving into a masked stage die as well.
      kill    = flush ? (valid_pre & FLUSH_MASK) : '0;
      valid_d = valid_pre & ~kill;
      count_d = popcount(valid_d);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         count_q <= '0;
         for (int i = 0; i < STAGES; i++) data_q[i] <= '0;
      end else begin
         valid_q <= valid_d;
         count_q <= count_d;
         for (int i = 0; i < STAGES; i++) data_q[i] <= data_d[i];
      end
   end

`ifdef ARM_ELASTIC_PIPE_STATS_EN
   logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cnt_d = sat_add(stall_cnt_q, CW'(in_valid & ~in_ready));
      flush_cnt_d = sat_add(flush_cnt_q, popcount(kill));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_arm_elastic_pipe.sv
// Self-checking bench for arm_elastic_pipe (STAGES=4, FLUSH_MASK=4'b0011): vector table plus
// hand-written streaming / freeze / flush sequences, with a queue scoreboard on the output side.
module tb_arm_elastic_pipe;

   localparam int WIDTH  = 32;
   localparam int STAGES = 4;

   logic              clk = 1'b0;
   logic              rst, in_valid, in_ready, out_valid, out_ready, freeze, flush;
   logic [WIDTH-1:0]  in_data, out_data;
   logic [2:0]        count;
`ifdef ARM_ELASTIC_PIPE_STATS_EN
   logic [31:0]       stall_cnt, flush_cnt;
`endif

   arm_elastic_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .FLUSH_MASK(4'b0011)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .freeze(freeze), .flush(flush), .count(count)
`ifdef ARM_ELASTIC_PIPE_STATS_EN
      , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst, iv;
      logic [31:0] d;
      logic        ordy, frz, fl;
      logic        e_ir, e_ov;
      logic [2:0]  e_cnt;
   } vec_t;

   vec_t        tbl[$];
   logic [31:0] sb[$];
   int          checks = 0;
   int          errors = 0;

   function automatic vec_t mk(logic r, logic iv, logic [31:0] d, logic ordy, logic frz,
                               logic fl, logic e_ir, logic e_ov, logic [2:0] e_cnt);
      vec_t v;
      v.rst = r; v.iv = iv; v.d = d; v.ordy = ordy; v.frz = frz; v.fl = fl;
      v.e_ir = e_ir; v.e_ov = e_ov; v.e_cnt = e_cnt;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic r, input logic iv, input logic [31:0] d, input logic ordy,
                        input logic frz, input logic fl);
      rst = r; in_valid = iv; in_data = d; out_ready = ordy; freeze = frz; flush = fl;
   endtask

   // Scoreboard runs at the falling edge, where handshakes for the next rising edge are settled.
   task automatic sample();
      logic [31:0] exp;
      @(negedge clk);
      if (!rst) begin
         if (in_valid && in_ready) sb.push_back(in_data);
         if (out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL sb_underflow actual=%0h required=empty_output", out_data);
            end else begin
               exp = sb.pop_front();
               if (out_data !== exp) begin
                  errors++;
                  $display("FAIL sb_data actual=%0h required=%0h @%0t", out_data, exp, $time);
               end
            end
         end
      end
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
   endtask

   initial begin
      drive(1, 0, 0, 0, 0, 0);
      advance();

      // Reset with in_valid high, then A,idle,B,idle,C packing, D fill, full stall, full in+out, drain
      tbl.push_back(mk(1, 1, 32'hAA, 1, 0, 0, 1, 0, 0));
      tbl.push_back(mk(1, 1, 32'hAA, 1, 0, 0, 1, 0, 0));
      tbl.push_back(mk(1, 1, 32'hAA, 1, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 0, 32'h0,  0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 1, 32'hA1, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 0, 32'h0,  0, 0, 0, 1, 0, 1));
      tbl.push_back(mk(0, 1, 32'hB2, 0, 0, 0, 1, 0, 1));
      tbl.push_back(mk(0, 0, 32'h0,  0, 0, 0, 1, 0, 2));
      tbl.push_back(mk(0, 1, 32'hC3, 0, 0, 0, 1, 1, 2));
      tbl.push_back(mk(0, 0, 32'h0,  0, 0, 0, 1, 1, 3));
      tbl.push_back(mk(0, 0, 32'h0,  0, 0, 0, 1, 1, 3));
      tbl.push_back(mk(0, 1, 32'hD4, 0, 0, 0, 1, 1, 3));
      tbl.push_back(mk(0, 0, 32'h0,  0, 0, 0, 0, 1, 4));
      tbl.push_back(mk(0, 1, 32'hE5, 0, 0, 0, 0, 1, 4));
      tbl.push_back(mk(0, 1, 32'hF6, 1, 0, 0, 1, 1, 4));
      tbl.push_back(mk(0, 0, 32'h0,  1, 0, 0, 1, 1, 4));
      tbl.push_back(mk(0, 0, 32'h0,  1, 0, 0, 1, 1, 3));
      tbl.push_back(mk(0, 0, 32'h0,  1, 0, 0, 1, 1, 2));
      tbl.push_back(mk(0, 0, 32'h0,  1, 0, 0, 1, 1, 1));
      tbl.push_back(mk(0, 0, 32'h0,  1, 0, 0, 1, 0, 0));

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].rst, tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].frz, tbl[i].fl);
         sample();
         chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].e_ir));
         chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
         chk($sformatf("vec%0d_count", i), 32'(count), 32'(tbl[i].e_cnt));
         advance();
      end
      chk("sb_empty_after_table", sb.size(), 0);

      // Streaming 1..8 back-to-back: first output STAGES cycles after first accept
      for (int c = 0; c < 14; c++) begin
         int acc, pop;
         drive(0, c < 8, 32'(c + 1), 1, 0, 0);
         sample();
         acc = (c < 8) ? c : 8;
         pop = (c - 4 < 0) ? 0 : ((c - 4 > 8) ? 8 : c - 4);
         chk($sformatf("stream%0d_out_valid", c), 32'(out_valid), 32'(c >= 4 && c < 12));
         chk($sformatf("stream%0d_count", c), 32'(count), 32'(acc - pop));
         chk($sformatf("stream%0d_in_ready", c), 32'(in_ready), 1);
         if (c == 4) chk("stream_first_data", out_data, 32'h1);
         advance();
      end

      // Freeze for 3 cycles mid-stream, then resume
      for (int c = 0; c < 6; c++) begin
         drive(0, 1, 32'h10 + 32'(c), 1, 0, 0);
         sample();
         advance();
      end
      for (int c = 0; c < 3; c++) begin
         drive(0, 1, 32'h16, 1, 1, 0);
         sample();
         chk($sformatf("freeze%0d_in_ready", c), 32'(in_ready), 0);
         chk($sformatf("freeze%0d_out_valid", c), 32'(out_valid), 0);
         chk($sformatf("freeze%0d_count", c), 32'(count), 4);
         chk($sformatf("freeze%0d_out_data", c), out_data, 32'h12);
         advance();
      end
      for (int c = 0; c < 2; c++) begin
         drive(0, 1, 32'h16 + 32'(c), 1, 0, 0);
         sample();
         if (c == 0) begin
            chk("resume_out_valid", 32'(out_valid), 1);
            chk("resume_out_data", out_data, 32'h12);
         end
         advance();
      end
      for (int c = 0; c < 6; c++) begin
         drive(0, 0, 0, 1, 0, 0);
         sample();
         advance();
      end
      drive(0, 0, 0, 0, 0, 0);
      sample();
      chk("freeze_drained_count", 32'(count), 0);
      chk("sb_empty_after_freeze", sb.size(), 0);
      advance();

      // Flush with mask 0011 on a full chain, then flush together with freeze
      for (int c = 0; c < 4; c++) begin
         drive(0, 1, 32'h20 + 32'(c), 0, 0, 0);
         sample();
         advance();
      end
      drive(0, 1, 32'h99, 0, 0, 1);
      sample();
      chk("flush_full_count", 32'(count), 4);
      chk("flush_in_ready", 32'(in_ready), 0);
      chk("flush_out_valid", 32'(out_valid), 1);
      advance();
      void'(sb.pop_back());
      void'(sb.pop_back());
      drive(0, 0, 0, 0, 0, 0);
      sample();
      chk("flush_count", 32'(count), 2);
      chk("flush_kept_head", out_data, 32'h20);
      advance();
      for (int c = 0; c < 2; c++) begin
         drive(0, 1, 32'h24 + 32'(c), 0, 0, 0);
         sample();
         chk($sformatf("refill%0d_in_ready", c), 32'(in_ready), 1);
         advance();
      end
      drive(0, 1, 32'h98, 0, 1, 1);
      sample();
      chk("flushfrz_full_count", 32'(count), 4);
      chk("flushfrz_in_ready", 32'(in_ready), 0);
      chk("flushfrz_out_valid", 32'(out_valid), 0);
      advance();
      void'(sb.pop_back());
      void'(sb.pop_back());
      drive(0, 0, 0, 0, 0, 0);
      sample();
      chk("flushfrz_count", 32'(count), 2);
      chk("flushfrz_head", out_data, 32'h20);
      advance();
`ifdef ARM_ELASTIC_PIPE_STATS_EN
      chk("stall_cnt", stall_cnt, 32'd6);
      chk("flush_cnt", flush_cnt, 32'd4);
`endif
      for (int c = 0; c < 4; c++) begin
         drive(0, 0, 0, 1, 0, 0);
         sample();
         advance();
      end
      drive(0, 0, 0, 0, 0, 0);
      sample();
      chk("final_count", 32'(count), 0);
      chk("final_out_valid", 32'(out_valid), 0);
      chk("sb_empty_final", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
